xbus_arbiter: RTL and testbench
===============================

Name: xbus_arbiter

Overview:
- Two-requester arbiter that owns the single selectable data bus feeding the system address decoder. Requester 0 is the controller core; requester 1 is the external/debug host.
- Serialises accesses, drives one-cycle decoder selects, and captures read data. Returns a registered acknowledge plus an error flag when the decoded address hits the trap region.
- Sits between the requesters and the address decoder.

Parameters:
- ADDR_W, `ADDR_W, address width of both requesters and the bus
- DATA_W, `DATA_W (32), data width
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins contention

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- m0_req  in  1  requester 0 access request, held until m0_ack
- m0_we  in  1  requester 0 write enable (1 = write)
- m0_addr  in  ADDR_W  requester 0 address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_ack  out  1  one-cycle completion pulse to requester 0
- m0_err  out  1  requester 0 access hit the trap region; valid with m0_ack
- m0_rdata  out  DATA_W  registered read data; valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as the m0_* ports, for requester 1
- bus_sel  out  1  global select to the decoder
- bus_we  out  1  write enable to the selected slave
- bus_addr  out  ADDR_W  address to the decoder
- bus_wdata  out  DATA_W  write data to slaves
- bus_rdata  in  DATA_W  decoder read mux output
- bus_trap  in  1  decoder trap select
- owner  out  1  requester currently (or last) granted

Behaviour:
- FSM states: IDLE, BUS, ACK. State and all registers are updated only on the rising edge of clk.
- Reset (rst==0 at an edge) forces:
  - state=IDLE, owner=1, rdata registers=0
  - all acks=0, all errs=0, bus_sel=0
- Reset mid-transfer abandons the transfer: no ack is issued, and bus_sel is 0 from the next cycle.
- IDLE:
  - No req: stay in IDLE.
  - Any req: latch the grant into owner and go to BUS.
  - Single requester: that requester wins.
  - Both requesting with FIXED_PRIO=0: grant !owner (alternate). Because owner resets to 1, requester 0 wins the first contention.
  - Both requesting with FIXED_PRIO=1: requester 0 wins.
- BUS (exactly one cycle):
  - bus_sel=1. bus_we, bus_addr and bus_wdata are muxed combinationally from the owner's inputs.
  - At the clock edge, bus_rdata is captured into owner's rdata register (reads and writes alike). bus_trap is captured into an err flag.
  - Next state is ACK.
- ACK (one cycle): owner's ack=1 and err=captured flag. The other requester's ack=0 and err=0. Next state is IDLE.
- Outside BUS: bus_sel=0, bus_we=0, bus_addr=0, bus_wdata=0.
- Latency: req sampled in IDLE at cycle t → bus_sel at t+1 → ack at t+2. The minimum period for back-to-back transfers is 3 cycles.
- Requesters must hold we/addr/wdata stable from req assertion through ack.
- A req still high during the ACK cycle is treated as a new request when IDLE samples it.
- A req dropped before it is granted is simply not serviced. No ack is produced.
- m*_rdata holds its value until that requester's next completed transfer.
- err does not block the transfer: bus_sel still pulses, and a trapped read returns whatever bus_rdata held (0 from the decoder).
- No starvation: with FIXED_PRIO=0 and both requesters continuously requesting, grants strictly alternate.

Test Plan:
- Reset, then m0 read of addr 0x0004 with bus_rdata=0xDEADBEEF → bus_sel high exactly 1 cycle at t+1; m0_ack at t+2; m0_rdata=0xDEADBEEF; m0_err=0; m1_ack stays 0.
- m1 write of addr 0x0100, data 0x12345678 → in the BUS cycle bus_we=1, bus_addr=0x0100, bus_wdata=0x12345678; m1_ack one cycle later.
- FIXED_PRIO=0, m0_req and m1_req both held high for 4 transfers → grant order m0, m1, m0, m1; each ack 3 cycles apart.
- FIXED_PRIO=1, same stimulus → only m0 is acked while m0_req is high. Once m0 drops, m1 is served.
- m0 access to an unmapped address with bus_trap=1 during BUS → m0_ack=1 and m0_err=1 in the same cycle; m0_err=0 on the next transfer to a mapped address.
- rst driven low during the BUS cycle → bus_sel=0 and state IDLE from the next cycle, no ack ever pulses for that request. After rst returns high, the held m0_req is serviced normally.

Source files
------------

// File: rtl/xbus_arbiter.sv
// Two-requester arbiter for the shared decoder bus.
// Serialises accesses as IDLE -> BUS -> ACK and returns registered read data.
module xbus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_sel,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_trap,
    output logic              owner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              grant;

    // Contention goes to m0 in fixed mode, otherwise to whoever did not own last.
    always_comb begin
        if (m0_req && m1_req) begin
            grant = FIXED_PRIO ? 1'b0 : ~owner_q;
        end else begin
            grant = m1_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = grant;
                    state_d = BUS;
                end
            end
            BUS: begin
                err_d = bus_trap;
                if (owner_q) begin
                    rdata1_d = bus_rdata;
                end else begin
                    rdata0_d = bus_rdata;
                end
                state_d = ACK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b1;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        bus_sel   = (state_q == BUS);
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (bus_sel) begin
            bus_we    = owner_q ? m1_we    : m0_we;
            bus_addr  = owner_q ? m1_addr  : m0_addr;
            bus_wdata = owner_q ? m1_wdata : m0_wdata;
        end
    end

    assign m0_ack   = (state_q == ACK) && !owner_q;
    assign m1_ack   = (state_q == ACK) &&  owner_q;
    assign m0_err   = m0_ack && err_q;
    assign m1_err   = m1_ack && err_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: round-robin and fixed-priority instances
// share all inputs and are checked against hand-computed expectations.
module tb_xbus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, bus_rdata;
    logic          bus_trap;

    logic          a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_bus_wdata;
    logic          a_bus_sel, a_bus_we, a_owner;
    logic [AW-1:0] a_bus_addr;

    logic          b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_bus_wdata;
    logic          b_bus_sel, b_bus_we, b_owner;
    logic [AW-1:0] b_bus_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
        .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
        .m1_rdata(a_m1_rdata),
        .bus_sel(a_bus_sel), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
        .bus_wdata(a_bus_wdata), .bus_rdata(bus_rdata),
        .bus_trap(bus_trap), .owner(a_owner)
    );

    xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
        .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
        .m1_rdata(b_m1_rdata),
        .bus_sel(b_bus_sel), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
        .bus_wdata(b_bus_wdata), .bus_rdata(bus_rdata),
        .bus_trap(bus_trap), .owner(b_owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_rr, exp_fp;

        rst       = 1'b0;
        m0_req    = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req    = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        bus_rdata = '0;
        bus_trap  = 1'b0;
        tick();
        tick();
        chk("rst_sel", a_bus_sel, 1'b0);
        chk("rst_ack", {a_m1_ack, a_m0_ack}, 2'b00);
        chk("rst_err", {a_m1_err, a_m0_err}, 2'b00);
        chk("rst_owner", a_owner, 1'b1);
        chk("rst_rdata0", a_m0_rdata, 32'h0);
        chk("rst_bus_addr", a_bus_addr, 16'h0);
        rst = 1'b1;
        tick();
        chk("idle_sel", a_bus_sel, 1'b0);

        // m0 read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0004;
        bus_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_sel", a_bus_sel, 1'b1);
        chk("rd_addr", a_bus_addr, 16'h0004);
        chk("rd_we", a_bus_we, 1'b0);
        chk("rd_owner", a_owner, 1'b0);
        chk("rd_ack_early", a_m0_ack, 1'b0);
        tick();
        chk("rd_ack", {a_m1_ack, a_m0_ack}, 2'b01);
        chk("rd_err", a_m0_err, 1'b0);
        chk("rd_data", a_m0_rdata, 32'hDEADBEEF);
        chk("rd_sel_off", a_bus_sel, 1'b0);
        m0_req = 1'b0;
        tick();
        chk("rd_ack_off", a_m0_ack, 1'b0);

        // m1 write
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0100;
        m1_wdata = 32'h12345678;
        tick();
        chk("wr_sel", a_bus_sel, 1'b1);
        chk("wr_we", a_bus_we, 1'b1);
        chk("wr_addr", a_bus_addr, 16'h0100);
        chk("wr_wdata", a_bus_wdata, 32'h12345678);
        chk("wr_owner", a_owner, 1'b1);
        tick();
        chk("wr_ack", {a_m1_ack, a_m0_ack}, 2'b10);
        chk("wr_err", a_m1_err, 1'b0);
        chk("wr_rdata0_hold", a_m0_rdata, 32'hDEADBEEF);
        m1_req = 1'b0; m1_we = 1'b0;
        tick();

        // contention: both held for 12 cycles
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0010;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_rr = (i == 2 || i == 8) ? 2'b01 :
                     (i == 5 || i == 11) ? 2'b10 : 2'b00;
            exp_fp = (i == 2 || i == 5 || i == 8 || i == 11) ? 2'b01 : 2'b00;
            chk($sformatf("rr_ack_c%0d", i), {a_m1_ack, a_m0_ack}, exp_rr);
            chk($sformatf("fp_ack_c%0d", i), {b_m1_ack, b_m0_ack}, exp_fp);
        end
        m0_req = 1'b0;
        tick();
        chk("fp_m1_owner", b_owner, 1'b1);
        tick();
        chk("fp_m1_ack", {b_m1_ack, b_m0_ack}, 2'b10);
        chk("rr_m1_ack", {a_m1_ack, a_m0_ack}, 2'b10);
        m1_req = 1'b0;
        tick();

        // trapped access then mapped access
        m0_req = 1'b1; m0_addr = 16'hFF00; bus_rdata = 32'h0; bus_trap = 1'b1;
        tick();
        chk("trap_sel", a_bus_sel, 1'b1);
        tick();
        chk("trap_ack", a_m0_ack, 1'b1);
        chk("trap_err", {a_m1_err, a_m0_err}, 2'b01);
        chk("trap_rdata", a_m0_rdata, 32'h0);
        m0_req = 1'b0; bus_trap = 1'b0;
        tick();
        chk("trap_err_off", a_m0_err, 1'b0);
        m0_req = 1'b1; m0_addr = 16'h0008; bus_rdata = 32'hCAFE0001;
        tick();
        tick();
        chk("map_ack", a_m0_ack, 1'b1);
        chk("map_err", a_m0_err, 1'b0);
        chk("map_rdata", a_m0_rdata, 32'hCAFE0001);
        m0_req = 1'b0;
        tick();

        // reset during BUS
        m0_req = 1'b1; m0_addr = 16'h0020; bus_rdata = 32'h5A5A5A5A;
        tick();
        chk("mid_sel", a_bus_sel, 1'b1);
        rst = 1'b0;
        tick();
        chk("mid_rst_sel", a_bus_sel, 1'b0);
        chk("mid_rst_ack", {a_m1_ack, a_m0_ack}, 2'b00);
        chk("mid_rst_owner", a_owner, 1'b1);
        chk("mid_rst_rdata0", a_m0_rdata, 32'h0);
        chk("mid_rst_rdata1", a_m1_rdata, 32'h0);
        rst = 1'b1;
        tick();
        chk("post_sel", a_bus_sel, 1'b1);
        chk("post_ack_early", a_m0_ack, 1'b0);
        tick();
        chk("post_ack", {a_m1_ack, a_m0_ack}, 2'b01);
        chk("post_rdata", a_m0_rdata, 32'h5A5A5A5A);
        m0_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
